// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the seven-segment display path: segment bit order
// (same as the number-to-segment-code converter), the all-zero and all-off
// codes, the digit count and the scan sequencer state type.
// ---------------------------------------------------------------------------
package seg_pkg;

    // Segment bit order within one digit byte: bit7..bit0 = a,b,c,d,e,f,g,dp.
    // A 1 lights the segment.
    localparam int SEG_A  = 7;
    localparam int SEG_B  = 6;
    localparam int SEG_C  = 5;
    localparam int SEG_D  = 4;
    localparam int SEG_E  = 3;
    localparam int SEG_F  = 2;
    localparam int SEG_G  = 1;
    localparam int SEG_DP = 0;

    localparam logic [7:0] SEG_ZERO = 8'hfc;  // digit "0": a..f lit
    localparam logic [7:0] SEG_OFF  = 8'h00;  // nothing lit
    localparam int         NUM_DIG  = 3;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    // Active-high one-hot enable for a digit index (0 ones, 1 tens, 2 hundreds).
    function automatic logic [NUM_DIG-1:0] dig_onehot(input logic [1:0] idx);
        logic [NUM_DIG-1:0] oh;
        case (idx)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            default: oh = 3'b100;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// ---------------------------------------------------------------------------
// seg_scan_timer
// Scan sequencer: alternates BLANK (BLANK_CYC cycles) and SHOW (CLK_DIV
// cycles) per digit, stepping ones -> tens -> hundreds -> ones.
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous active-low reset
//   idx_nxt    out  digit index that will be current after the next edge
//   phase_nxt  out  scan phase that will be current after the next edge
//   snap_en    out  the next edge leaves the BLANK in front of the ones digit
//   frame_end  out  the next edge leaves the SHOW of the hundreds digit
//
// The *_nxt values and strobes are consumed by the output registers in the
// parent so the pins change on the same edge as the sequencer state.
// ---------------------------------------------------------------------------
module seg_scan_timer
    import seg_pkg::*;
#(
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic [1:0]  idx_nxt,
    output scan_state_t phase_nxt,
    output logic        snap_en,
    output logic        frame_end
);

    localparam int CNT_MAX = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

    scan_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [1:0]       idx_q,   idx_d;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves it unassigned; that is what keeps this block latch-free.
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        idx_d     = idx_q;
        snap_en   = 1'b0;
        frame_end = 1'b0;

        if (state_q == BLANK) begin
            if (cnt_q == BLANK_LAST) begin
                state_d = SHOW;
                cnt_d   = '0;
                // The code is latched only in front of the ones digit so a
                // frame never mixes digits from two different codes.
                snap_en = (idx_q == 2'd0);
            end
        end else begin
            if (cnt_q == SHOW_LAST) begin
                state_d   = BLANK;
                cnt_d     = '0;
                idx_d     = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
                frame_end = (idx_q == 2'd2);
            end
        end
    end

    // NOTE: sequential state is written only with non-blocking assignments so
    // every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= BLANK;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    assign idx_nxt   = idx_d;
    assign phase_nxt = state_d;

endmodule

// File: rtl/seg_scan.sv
// ---------------------------------------------------------------------------
// seg_scan
// Time-multiplexed driver for a three-digit seven-segment display. Shows
// ones, tens, hundreds in turn with a blanking gap before each digit,
// latches a new code only at frame boundaries and optionally suppresses
// leading zeros.
//
// Ports
//   clk         in   system clock
//   rst         in   asynchronous active-low reset
//   my_code     in   [23:16] hundreds, [15:8] tens, [7:0] ones segment codes
//   blank_lz    in   1 = suppress leading zeros (latched with my_code)
//   seg_out     out  segment lines of the active digit (registered)
//   dig_sel     out  digit enables, bit0 ones .. bit2 hundreds (registered)
//   frame_done  out  one-cycle pulse on the first BLANK after hundreds
// ---------------------------------------------------------------------------
module seg_scan
    import seg_pkg::*;
#(
    parameter int CLK_DIV        = 50000,
    parameter int BLANK_CYC      = 16,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] my_code,
    input  logic        blank_lz,
    output logic [7:0]  seg_out,
    output logic [2:0]  dig_sel,
    output logic        frame_done
);

    localparam logic [NUM_DIG-1:0] DIG_OFF = DIG_ACTIVE_LOW ? 3'b111 : 3'b000;

    logic [1:0]  idx_nxt;
    scan_state_t phase_nxt;
    logic        snap_en;
    logic        frame_end;

    seg_scan_timer #(
        .CLK_DIV   (CLK_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .idx_nxt   (idx_nxt),
        .phase_nxt (phase_nxt),
        .snap_en   (snap_en),
        .frame_end (frame_end)
    );

    logic [23:0]        snap_q, snap_d;
    logic               lz_q,   lz_d;
    logic [7:0]         seg_q,  seg_d;
    logic [NUM_DIG-1:0] dig_q,  dig_d;
    logic               frame_q, frame_d;

    logic       hund_blank;
    logic       tens_blank;
    logic       digit_blank;
    logic [7:0] digit_code;
    logic [2:0] digit_on;

    always_comb begin
        snap_d = snap_en ? my_code  : snap_q;
        lz_d   = snap_en ? blank_lz : lz_q;

        // Leading zeros cascade from the hundreds downwards; ones always shows.
        hund_blank = lz_d && (snap_d[23:16] == SEG_ZERO);
        tens_blank = hund_blank && (snap_d[15:8] == SEG_ZERO);

        case (idx_nxt)
            2'd0: begin
                digit_code  = snap_d[7:0];
                digit_blank = 1'b0;
            end
            2'd1: begin
                digit_code  = snap_d[15:8];
                digit_blank = tens_blank;
            end
            default: begin
                digit_code  = snap_d[23:16];
                digit_blank = hund_blank;
            end
        endcase

        digit_on = DIG_ACTIVE_LOW ? ~dig_onehot(idx_nxt) : dig_onehot(idx_nxt);

        // Outputs are computed from the post-edge sequencer state so they
        // register on the same edge the state changes.
        seg_d = SEG_OFF;
        dig_d = DIG_OFF;
        if ((phase_nxt == SHOW) && !digit_blank) begin
            seg_d = digit_code;
            dig_d = digit_on;
        end

        frame_d = frame_end;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap_q  <= '0;
            lz_q    <= 1'b0;
            seg_q   <= SEG_OFF;
            dig_q   <= DIG_OFF;
            frame_q <= 1'b0;
        end else begin
            snap_q  <= snap_d;
            lz_q    <= lz_d;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
            frame_q <= frame_d;
        end
    end

    assign seg_out    = seg_q;
    assign dig_sel    = dig_q;
    assign frame_done = frame_q;

endmodule

// File: tb/tb_seg_scan.sv
// ---------------------------------------------------------------------------
// tb_seg_scan
// Scoreboard bench for seg_scan with CLK_DIV=4, BLANK_CYC=2, active-low
// digit enables. A reference model derives each cycle's expected display
// from the cycle number since reset release and pushes it into a queue; a
// monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_seg_scan;

    localparam int CLK_DIV   = 4;
    localparam int BLANK_CYC = 2;
    localparam int DIGIT_LEN = BLANK_CYC + CLK_DIV;   // 6
    localparam int FRAME_LEN = 3 * DIGIT_LEN;         // 18

    logic        clk;
    logic        rst;
    logic [23:0] my_code;
    logic        blank_lz;
    logic [7:0]  seg_out;
    logic [2:0]  dig_sel;
    logic        frame_done;

    seg_scan #(
        .CLK_DIV        (CLK_DIV),
        .BLANK_CYC      (BLANK_CYC),
        .DIG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .my_code    (my_code),
        .blank_lz   (blank_lz),
        .seg_out    (seg_out),
        .dig_sel    (dig_sel),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [7:0] seg;
        logic [2:0] dig;
        logic       fd;
        int         k;
    } exp_t;

    exp_t sb_q[$];

    // ------------------------------------------------------------------
    // Reference model. k counts rising edges since reset release. Within a
    // frame, position p = k mod 18: each digit slot is 6 cycles long, the
    // first 2 blank, the last 4 showing. A new code is taken whenever p==2.
    // ------------------------------------------------------------------
    int          k = 0;
    logic [23:0] m_snap = '0;
    logic        m_lz = 1'b0;

    always @(posedge clk) begin
        if (!rst) begin
            k      = 0;
            m_snap = '0;
            m_lz   = 1'b0;
        end else begin
            exp_t e;
            int   pos;
            int   slot;
            logic lead;
            k++;
            pos  = k % FRAME_LEN;
            slot = pos / DIGIT_LEN;
            if (pos == BLANK_CYC) begin
                m_snap = my_code;
                m_lz   = blank_lz;
            end
            e.seg = 8'h00;
            e.dig = 3'b111;
            e.fd  = (pos == 0);
            e.k   = k;
            if ((pos % DIGIT_LEN) >= BLANK_CYC) begin
                // A digit is a leading zero when it and every higher digit
                // read as zero; the ones digit is never treated that way.
                lead = m_lz && (slot > 0);
                for (int s = slot; s < 3; s++)
                    if (m_snap[8*s +: 8] != 8'hfc) lead = 1'b0;
                if (!lead) begin
                    e.seg = m_snap[8*slot +: 8];
                    e.dig = ~(3'b001 << slot);
                end
            end
            sb_q.push_back(e);
        end
    end

    // Monitor: compare on the falling edge, away from the active edge.
    int pops = 0;
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            pops++;
            check($sformatf("seg_out k=%0d", e.k),    32'(seg_out),    32'(e.seg));
            check($sformatf("dig_sel k=%0d", e.k),    32'(dig_sel),    32'(e.dig));
            check($sformatf("frame_done k=%0d", e.k), 32'(frame_done), 32'(e.fd));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic run_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Advance to the falling edge where the model sits at frame position p.
    task automatic wait_pos(input int p);
        int guard = 0;
        @(negedge clk);
        while ((k % FRAME_LEN) != p && guard < 2 * FRAME_LEN) begin
            @(negedge clk);
            guard++;
        end
        check($sformatf("wait_pos %0d timeout", p), 32'(guard < 2 * FRAME_LEN), 32'd1);
    endtask

    function automatic logic [23:0] rand_code();
        logic [23:0] c;
        for (int b = 0; b < 3; b++) begin
            case ($urandom_range(0, 3))
                0, 1:    c[8*b +: 8] = 8'hfc;
                2:       c[8*b +: 8] = 8'h00;
                default: c[8*b +: 8] = 8'($urandom);
            endcase
        end
        return c;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, " seg_out"},    32'(seg_out),    32'h00);
        check({tag, " dig_sel"},    32'(dig_sel),    32'b111);
        check({tag, " frame_done"}, 32'(frame_done), 32'd0);
    endtask

    initial begin
        rst      = 1'b0;
        my_code  = 24'h60dab6;
        blank_lz = 1'b0;

        // Held in reset across several clock edges.
        run_cycles(3);
        check_reset_outputs("hold_reset");

        rst = 1'b1;   // released on a falling edge

        // Scan order and frame pulse with a plain code.
        run_cycles(2 * FRAME_LEN);

        // Code changes during the tens SHOW must not appear until next frame.
        wait_pos(9);
        my_code = 24'hf6f6f6;
        run_cycles(2 * FRAME_LEN);

        // Leading-zero suppression.
        my_code  = 24'h60dab6;
        run_cycles(FRAME_LEN);
        my_code  = 24'hfcfc60;
        blank_lz = 1'b1;
        run_cycles(2 * FRAME_LEN);
        my_code  = 24'hfc60fc;
        run_cycles(2 * FRAME_LEN);
        my_code  = 24'hfcfc60;
        blank_lz = 1'b0;
        run_cycles(2 * FRAME_LEN);

        // Randomized codes and flag, changing at arbitrary cycles.
        for (int i = 0; i < 30 * FRAME_LEN; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0)  my_code  = rand_code();
            if ($urandom_range(0, 15) == 0) blank_lz = 1'($urandom_range(0, 1));
        end

        // Asynchronous reset in the middle of the ones SHOW window.
        wait_pos(4);
        check("pre_reset dig_sel", 32'(dig_sel), 32'b110);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        run_cycles(3);
        check_reset_outputs("async_hold");
        rst = 1'b1;

        for (int i = 0; i < 4 * FRAME_LEN; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) my_code  = rand_code();
            if ($urandom_range(0, 9) == 0) blank_lz = 1'($urandom_range(0, 1));
        end

        // Every model entry must have been compared.
        @(negedge clk);
        #1;
        check("scoreboard drained", 32'(sb_q.size()), 32'd0);
        check("monitor activity", 32'(pops > 40 * FRAME_LEN), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan.md
# seg_scan

Time-multiplexed driver for the three-digit seven-segment display. It sits directly downstream of the number-to-segment-code converter and takes its 24-bit packed segment codes. Each frame it shows the three digits in turn, with a blanking gap between digits so the display does not ghost. It latches a new code only at frame boundaries so a digit never tears mid-frame, and it can suppress leading zeros.

## Interface
- CLK_DIV, 50000, SHOW length per digit in clk cycles (≥2); 1 kHz digit rate at 50 MHz
- BLANK_CYC, 16, blanking gap before each digit in clk cycles (≥1)
- DIG_ACTIVE_LOW, 1, 1: digit enables active-low; 0: active-high
- clk  in  1  system clock; one clock domain only
- rst  in  1  asynchronous, active-low reset
- my_code  in  24  packed segment codes: [23:16] hundreds, [15:8] tens, [7:0] ones; byte bit7..bit0 = a,b,c,d,e,f,g,dp; 1 = segment lit
- blank_lz  in  1  1 = suppress leading zeros (sampled with my_code)
- seg_out  out  8  segment lines for the active digit, same bit order as my_code bytes
- dig_sel  out  3  digit enables: bit0 ones, bit1 tens, bit2 hundreds
- frame_done  out  1  one-cycle pulse at the end of each full frame

## Operation
- Registers: state {BLANK, SHOW}, cnt (wide enough for max(CLK_DIV, BLANK_CYC)-1), idx (0..2), snap[23:0], lz_snap.
- BLANK, cnt==BLANK_CYC-1: go to SHOW with cnt=0. If idx==0, also load snap<=my_code and lz_snap<=blank_lz. Otherwise cnt++.
- SHOW, cnt==CLK_DIV-1: go to BLANK with cnt=0 and idx = (idx==2) ? 0 : idx+1. frame_done=1 for this transition when idx was 2. Otherwise cnt++.
- Order each frame: ones (idx 0), then tens (1), then hundreds (2), then wrap to ones.
- Leading-zero rule, applied only when lz_snap=1, with zero code = 8'hfc:
  - Hundreds is blanked if snap[23:16]==8'hfc.
  - Tens is blanked if hundreds is blanked and snap[15:8]==8'hfc.
  - Ones is never blanked.
- A blanked digit behaves exactly like BLANK for its SHOW window: seg_out=8'h00, all enables inactive.
- Any code other than 8'hfc is passed through unmodified. This includes 8'h00 and invalid patterns. No decoding is done here.
- Inactive enable value: 3'b111 if DIG_ACTIVE_LOW, else 3'b000. Exactly one enable is active during SHOW of a non-blanked digit, never more.

## Timing
- All outputs are registered and updated on the same edge as state. Nothing combinational reaches the pins.
- Reset (asynchronous assert, takes effect immediately, including mid-SHOW):
  - Registers: state=BLANK, cnt=0, idx=0, snap=0, lz_snap=0.
  - Outputs: seg_out=8'h00, dig_sel=inactive, frame_done=0.
- After reset release: BLANK_CYC blank cycles, then ones digit. The first snapshot is taken on the edge that leaves the first BLANK.
- Frame period is 3·(BLANK_CYC+CLK_DIV) cycles. frame_done asserts on the first cycle of the BLANK that follows the hundreds digit.
- Changes to my_code or blank_lz during a frame have no visible effect until the next snapshot.
- Counter wrap: cnt resets to 0 on every state change. No other wrap condition exists.

## Structure
- Shared package seg_pkg holds:
  - SEG_ZERO=8'hfc, SEG_OFF=8'h00, NUM_DIG=3
  - scan_state_t enum {BLANK, SHOW}
  - Same segment bit-order definition used by the converter.
- One sub-module is natural: seg_scan_timer, containing the state/cnt/idx sequencer. It outputs idx, phase, snap_en and frame_end. The top adds snapshot, leading-zero masking and output registers.

## Test plan
All tests use CLK_DIV=4, BLANK_CYC=2, DIG_ACTIVE_LOW=1.
- Reset: hold rst=0 → seg_out=00, dig_sel=111, frame_done=0. Assert rst mid-SHOW → outputs return to the same values the same cycle, without waiting for a clock edge.
- Scan order: my_code=24'h60dab6, blank_lz=0 → after 2 blank cycles:
  - ones: b6 with dig_sel=110 for 4 cycles
  - then 2 blank cycles (seg 00 / dig_sel 111)
  - tens: da with dig_sel=101 for 4 cycles
  - hundreds: 60 with dig_sel=011
  - then repeat.
- Frame pulse: frame_done high for exactly 1 cycle, every 18 cycles, on the first blank cycle after the hundreds digit.
- Leading zeros, with blank_lz=1:
  - my_code=24'hfcfc60 → only the ones digit shows 60; the tens and hundreds windows show 00/111.
  - my_code=24'hfc60fc → hundreds blanked; tens shows 60; ones shows fc.
  - blank_lz=0 → all three digits shown.
- Snapshot: change my_code from 24'h60dab6 to 24'hf6f6f6 during the tens SHOW → hundreds still shows 60 in this frame; f6 appears from the next frame's ones digit.
